// File: rtl/tx_8b10b_sequencer.sv
// tx_8b10b_sequencer
// Drives the data, K-flag, enable and compliance inputs of an 8B/10B encoder.
// It sends an alignment burst after link enable, then forwards upstream words
// (or idles) with periodic skip ordered sets. It also runs the compliance
// CA/CB pattern on request. One word is emitted per enabled cycle; the
// encoder-facing outputs are registered.
module tx_8b10b_sequencer #(
  parameter int DATA_BYTES    = 2,
  parameter int ALIGN_WORDS   = 16,
  parameter int SKIP_INTERVAL = 1024,
  parameter int SKIP_WORDS    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_link_en,
  input  logic                    i_tx_enable,
  input  logic                    i_compliance_req,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_BYTES*8-1:0] i_data,
  input  logic [DATA_BYTES-1:0]   i_datak,
  output logic                    o_enc_enable,
  output logic                    o_enc_compliance,
  output logic [DATA_BYTES*8-1:0] o_enc_data,
  output logic [DATA_BYTES-1:0]   o_enc_datak,
  output logic                    o_link_up,
  output logic [2:0]              o_state
);
  localparam int DW = DATA_BYTES * 8;
  localparam int AW = $clog2(ALIGN_WORDS) + 1;
  localparam int IW = $clog2(SKIP_INTERVAL) + 1;
  localparam int SW = $clog2(SKIP_WORDS) + 1;

  localparam logic [DW-1:0]         ALIGN_DATA = {DATA_BYTES{8'hBC}};
  localparam logic [DW-1:0]         SKIP_DATA  = {DATA_BYTES{8'h1C}};
  localparam logic [DW-1:0]         CB_DATA    = {DATA_BYTES{8'hB5}};
  localparam logic [DATA_BYTES-1:0] ALL_K      = '1;
  localparam logic [DATA_BYTES-1:0] IDLE_K     = DATA_BYTES'(1);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_ALIGN = 3'd1,
    S_RUN   = 3'd2,
    S_SKIP  = 3'd3,
    S_COMP  = 3'd4
  } state_t;

  state_t              r_state, w_state_next;
  logic [AW-1:0]       r_align_cnt, w_align_cnt_next;
  logic [IW-1:0]       r_skip_cnt, w_skip_cnt_next;
  logic [SW-1:0]       r_skipw_cnt, w_skipw_cnt_next;
  logic                r_phase_cb, w_phase_cb_next;   // 1 = next compliance word is CB
  logic                r_first_ca, w_first_ca_next;   // next CA is the first after entry
  logic                w_emit;
  logic                w_word_comp;
  logic [DW-1:0]       w_word_data;
  logic [DATA_BYTES-1:0] w_word_k;
  logic                w_fire;
  logic [DW-1:0]       w_idle_data;

  // IDLE word: K28.5 in byte 0, D16.2 in every other byte
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_idle
      assign w_idle_data[gi*8 +: 8] = (gi == 0) ? 8'hBC : 8'h50;
    end
  endgenerate

  assign o_ready = i_tx_enable && i_link_en && !i_compliance_req && (r_state == S_RUN);
  assign w_fire  = i_valid && o_ready;

  // Next-state, counter updates and the word to emit this cycle
  always_comb begin
    w_state_next     = r_state;
    w_align_cnt_next = r_align_cnt;
    w_skip_cnt_next  = r_skip_cnt;
    w_skipw_cnt_next = r_skipw_cnt;
    w_phase_cb_next  = r_phase_cb;
    w_first_ca_next  = r_first_ca;
    w_emit           = 1'b0;
    w_word_comp      = 1'b0;
    w_word_data      = '0;
    w_word_k         = '0;
    if (!i_link_en) begin
      w_state_next = S_OFF;
    end else if (i_tx_enable) begin
      case (r_state)
        S_OFF: begin
          w_state_next     = S_ALIGN;
          w_align_cnt_next = '0;
        end
        S_ALIGN: begin
          w_emit           = 1'b1;
          w_word_data      = ALIGN_DATA;
          w_word_k         = ALL_K;
          w_align_cnt_next = r_align_cnt + AW'(1);
          if (r_align_cnt == AW'(ALIGN_WORDS - 1)) begin
            w_state_next    = S_RUN;
            w_skip_cnt_next = '0;
          end
        end
        S_RUN: begin
          w_emit          = 1'b1;
          w_word_data     = w_fire ? i_data : w_idle_data;
          w_word_k        = w_fire ? i_datak : IDLE_K;
          w_skip_cnt_next = r_skip_cnt + IW'(1);
          if (r_skip_cnt == IW'(SKIP_INTERVAL - 1)) begin
            w_state_next     = S_SKIP;
            w_skipw_cnt_next = '0;
          end
        end
        S_SKIP: begin
          w_emit           = 1'b1;
          w_word_data      = SKIP_DATA;
          w_word_k         = ALL_K;
          w_skipw_cnt_next = r_skipw_cnt + SW'(1);
          if (r_skipw_cnt == SW'(SKIP_WORDS - 1)) begin
            w_state_next    = S_RUN;
            w_skip_cnt_next = '0;
          end
        end
        S_COMP: begin
          w_emit = 1'b1;
          if (!r_phase_cb) begin
            w_word_data     = ALIGN_DATA;
            w_word_k        = ALL_K;
            w_word_comp     = r_first_ca;
            w_first_ca_next = 1'b0;
            w_phase_cb_next = 1'b1;
          end else begin
            w_word_data     = CB_DATA;
            w_word_k        = '0;
            w_phase_cb_next = 1'b0;
            // A release is only honoured once the CB closes the pair
            if (!i_compliance_req) begin
              w_state_next     = S_ALIGN;
              w_align_cnt_next = '0;
            end
          end
        end
        default: w_state_next = S_OFF;
      endcase
      // Compliance entry overrides the normal transition; this cycle's word still goes out
      if (i_compliance_req && (r_state inside {S_ALIGN, S_RUN, S_SKIP})) begin
        w_state_next    = S_COMP;
        w_phase_cb_next = 1'b0;
        w_first_ca_next = 1'b1;
      end
    end
  end

  // State, counters and registered encoder/status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_OFF;
      r_align_cnt      <= '0;
      r_skip_cnt       <= '0;
      r_skipw_cnt      <= '0;
      r_phase_cb       <= 1'b0;
      r_first_ca       <= 1'b0;
      o_enc_enable     <= 1'b0;
      o_enc_compliance <= 1'b0;
      o_enc_data       <= '0;
      o_enc_datak      <= '0;
      o_link_up        <= 1'b0;
      o_state          <= 3'd0;
    end else begin
      r_state          <= w_state_next;
      r_align_cnt      <= w_align_cnt_next;
      r_skip_cnt       <= w_skip_cnt_next;
      r_skipw_cnt      <= w_skipw_cnt_next;
      r_phase_cb       <= w_phase_cb_next;
      r_first_ca       <= w_first_ca_next;
      o_enc_enable     <= w_emit;
      o_enc_compliance <= w_word_comp;
      if (w_emit) begin
        o_enc_data  <= w_word_data;
        o_enc_datak <= w_word_k;
      end
      o_link_up <= (w_state_next == S_RUN) || (w_state_next == S_SKIP);
      o_state   <= w_state_next;
    end
  end

endmodule
